// File: rtl/logic_unit_pipe_pkg.sv
// logic_unit_pkg: opcodes, FSM state encoding and the per-bit logic op shared by the logic unit
package logic_unit_pkg;
  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_OR     = 3'd1;
  localparam logic [2:0] OP_XOR    = 3'd2;
  localparam logic [2:0] OP_NAND   = 3'd3;
  localparam logic [2:0] OP_NOR    = 3'd4;
  localparam logic [2:0] OP_XNOR   = 3'd5;
  localparam logic [2:0] OP_PASS_X = 3'd6;
  localparam logic [2:0] OP_NOT_X  = 3'd7;
  typedef enum logic {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_t;
  // Ops are purely bitwise, so one bit is evaluated here and replicated to WIDTH by the caller
  function automatic logic logic_op(input logic [2:0] op, input logic x, input logic y);
    case (op)
      OP_AND:    return x & y;
      OP_OR:     return x | y;
      OP_XOR:    return x ^ y;
      OP_NAND:   return ~(x & y);
      OP_NOR:    return ~(x | y);
      OP_XNOR:   return ~(x ^ y);
      OP_PASS_X: return x;
      default:   return ~x;
    endcase
  endfunction
endpackage

// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if: valid/ready operand and result channels of the logic unit
interface logic_unit_pipe_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_acc_en;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic             out_last;
  modport master (
    output in_valid, in_op, in_a, in_b, in_acc_en, in_last, out_ready,
    input  in_ready, out_valid, out_y, out_zero, out_last
  );
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_acc_en, in_last, out_ready,
    output in_ready, out_valid, out_y, out_zero, out_last
  );
endinterface

// File: rtl/logic_unit_pipe_op_core.sv
// logic_op_core: combinational WIDTH-bit evaluation of the eight logic ops
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] r
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign r[i] = logic_op(op, x[i], y[i]);
  end
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered logic unit with accumulate bursts and valid/ready handshake
// Optional handshake counter port stat_cnt when LOGIC_UNIT_PIPE_STATS_EN is defined.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef LOGIC_UNIT_PIPE_STATS_EN
  output logic [31:0]          stat_cnt,
`endif
  logic_unit_pipe_if.slave     bus
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, x, result, y_q;
  logic             valid_q, zero_q, last_q, accept, use_acc, acc_load;
  assign bus.in_ready  = !valid_q | bus.out_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_y     = y_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_last  = last_q;
  assign accept        = bus.in_valid & bus.in_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= ST_IDLE;
    else state_q <= state_d;
  always_comb
    state_d = !accept ? state_q :
              state_q == ST_IDLE ? ((bus.in_acc_en & !bus.in_last) ? ST_ACCUM : ST_IDLE) :
              (bus.in_last ? ST_IDLE : ST_ACCUM);
  // A single-beat burst (acc_en with last) leaves acc untouched
  always_comb begin
    use_acc  = state_q == ST_ACCUM;
    acc_load = accept & (use_acc | (bus.in_acc_en & !bus.in_last));
    x        = use_acc ? acc_q : bus.in_a;
  end
  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op (bus.in_op),
    .x  (x),
    .y  (bus.in_b),
    .r  (result)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= '0;
    else if (acc_load) acc_q <= result;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      zero_q  <= 1'b0;
      last_q  <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      y_q     <= result;
      zero_q  <= result == '0;
      last_q  <= bus.in_last;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
`ifdef LOGIC_UNIT_PIPE_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stat_cnt <= '0;
    else if (valid_q & bus.out_ready) stat_cnt <= stat_cnt + 32'd1;
`endif
endmodule
